// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main control unit: a Moore FSM that sequences
// fetch, decode, memory access, execute and write-back for six opcodes.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [2:0] alu_op,
  output logic       r_type,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ORIEX  = 4'd9,
    S_ORIWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_J   = 6'b000010;

  state_t state_r;

  function automatic logic op_legal(input logic [5:0] o);
    case (o)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ORI, OP_J: op_legal = 1'b1;
      default:                                  op_legal = 1'b0;
    endcase
  endfunction

  // State register and transition logic; op is only looked at in DECODE and MEMADR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      case (state_r)
        S_FETCH:  state_r <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_R:         state_r <= S_EXEC;
            OP_LW, OP_SW: state_r <= S_MEMADR;
            OP_BEQ:       state_r <= S_BRANCH;
            OP_ORI:       state_r <= S_ORIEX;
            OP_J:         state_r <= S_JUMP;
            default:      state_r <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (op == OP_LW) begin
            state_r <= S_MEMRD;
          end else if (op == OP_SW) begin
            state_r <= S_MEMWR;
          end else begin
            state_r <= S_FETCH;
          end
        end
        S_MEMRD:  state_r <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:  state_r <= S_FETCH;
        S_MEMWR:  state_r <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC:   state_r <= S_RWB;
        S_RWB:    state_r <= S_FETCH;
        S_BRANCH: state_r <= S_FETCH;
        S_ORIEX:  state_r <= S_ORIWB;
        S_ORIWB:  state_r <= S_FETCH;
        S_JUMP:   state_r <= S_FETCH;
        default:  state_r <= S_FETCH;
      endcase
    end
  end

  assign state = state_r;

  // Moore output decode; FETCH write strobes are qualified by mem_ready and reset
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    zero_ext      = 1'b0;
    alu_op        = 3'b000;
    r_type        = 1'b0;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready & rst_n;
        ir_write  = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~op_legal(op);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        r_type    = 1'b1;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b100;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        zero_ext  = 1'b1;
        alu_op    = 3'b010;
      end
      S_ORIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction scenarios,
// a mid-instruction reset, then randomized instructions against a sequence model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext, r_type, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [2:0] alu_op;
    logic       r_type;
    logic [1:0] pc_source;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    int st;
    bit mr;
  } cyc_t;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext),
    .alu_op(alu_op), .r_type(r_type), .pc_source(pc_source),
    .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
           (o == 6'b000100) || (o == 6'b001101) || (o == 6'b000010);
  endfunction

  // Expected outputs straight from the per-state output lists
  function automatic outs_t expect_outs(input int st, input bit mr, input logic [5:0] o);
    outs_t e = '0;
    case (st)
      0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.pc_write = mr; e.ir_write = mr; end
      1:  begin e.alu_src_b = 2'b11; e.illegal_op = !is_legal(o); end
      2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
      4:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      5:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
      6:  begin e.alu_src_a = 1'b1; e.r_type = 1'b1; end
      7:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      8:  begin e.alu_src_a = 1'b1; e.alu_op = 3'b100; e.pc_write_cond = 1'b1; e.pc_source = 2'b01; end
      9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.zero_ext = 1'b1; e.alu_op = 3'b010; end
      10: begin e.reg_write = 1'b1; end
      11: begin e.pc_write = 1'b1; e.pc_source = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input int st, input outs_t e);
    outs_t obs;
    obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext,
           alu_op, r_type, pc_source, illegal_op};
    n_assert++;
    assert (state === st[3:0]) else begin
      n_fail++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, st);
    end
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s outputs(state %0d) observed=%h expected=%h", tag, st, obs, e);
    end
  endtask

  // Build the expected cycle-by-cycle state walk of one instruction and play it
  task automatic play(input string tag, input logic [5:0] o, input int fw, input int mw);
    cyc_t seq[$];
    for (int i = 0; i < fw; i++) seq.push_back('{0, 1'b0});
    seq.push_back('{0, 1'b1});
    seq.push_back('{1, 1'($urandom)});
    case (o)
      6'b000000: begin seq.push_back('{6, 1'($urandom)}); seq.push_back('{7, 1'($urandom)}); end
      6'b100011: begin
        seq.push_back('{2, 1'($urandom)});
        for (int i = 0; i < mw; i++) seq.push_back('{3, 1'b0});
        seq.push_back('{3, 1'b1});
        seq.push_back('{4, 1'($urandom)});
      end
      6'b101011: begin
        seq.push_back('{2, 1'($urandom)});
        for (int i = 0; i < mw; i++) seq.push_back('{5, 1'b0});
        seq.push_back('{5, 1'b1});
      end
      6'b000100: seq.push_back('{8, 1'($urandom)});
      6'b001101: begin seq.push_back('{9, 1'($urandom)}); seq.push_back('{10, 1'($urandom)}); end
      6'b000010: seq.push_back('{11, 1'($urandom)});
      default: ;
    endcase
    foreach (seq[k]) begin
      @(negedge clk);
      mem_ready = seq[k].mr;
      op = (seq[k].st == 1 || seq[k].st == 2) ? o : 6'($urandom);
      #1;
      check(tag, seq[k].st, expect_outs(seq[k].st, seq[k].mr, op));
    end
  endtask

  initial begin
    outs_t er;
    logic [5:0] ops [8];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001101, 6'b000010, 6'b111111, 6'b010101};

    rst_n = 1'b0; mem_ready = 1'b1; op = 6'b100011;
    #1;
    er = expect_outs(0, 1'b1, op); er.pc_write = 1'b0; er.ir_write = 1'b0;
    check("reset_state", 0, er);
    @(negedge clk);
    mem_ready = 1'b0;
    #2 rst_n = 1'b1;

    play("lw_nowait", 6'b100011, 0, 0);
    play("sw_wait2", 6'b101011, 0, 2);
    play("beq", 6'b000100, 0, 0);
    play("illegal_3f", 6'b111111, 0, 0);
    play("rtype_fetchwait3", 6'b000000, 3, 0);
    play("ori", 6'b001101, 1, 0);
    play("jump", 6'b000010, 0, 0);
    play("lw_wait1", 6'b100011, 2, 1);

    // Reset pulsed while lw is waiting in MEMRD
    @(negedge clk); mem_ready = 1'b1; op = 6'b100011; #1; check("rst_fetch", 0, expect_outs(0, 1'b1, op));
    @(negedge clk); #1; check("rst_decode", 1, expect_outs(1, 1'b1, op));
    @(negedge clk); #1; check("rst_memadr", 2, expect_outs(2, 1'b1, op));
    @(negedge clk); mem_ready = 1'b0; #1; check("rst_memrd", 3, expect_outs(3, 1'b0, op));
    #1 rst_n = 1'b0;
    #1;
    er = expect_outs(0, 1'b0, op);
    check("rst_async", 0, er);
    @(negedge clk); mem_ready = 1'b1; #1;
    er = expect_outs(0, 1'b1, op); er.pc_write = 1'b0; er.ir_write = 1'b0;
    check("rst_held", 0, er);
    mem_ready = 1'b0;
    #1 rst_n = 1'b1;
    play("after_reset_beq", 6'b000100, 1, 0);

    for (int i = 0; i < 60; i++) begin
      play("random", ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 2));
    end

    @(negedge clk); mem_ready = 1'b0; #1;
    check("final_fetch", 0, expect_outs(0, 1'b0, op));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
